// File: rtl/signed_mult_seq_ctrl.sv
// Iterative signed/unsigned multiplier: one shared 2W-bit negator
// serves operand magnitudes and product sign restore around shift-add.
module signed_mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_NEGA = 3'd1;
  localparam logic [2:0] S_NEGB = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_NEGP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             nf_q, nf_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [PW-1:0]    neg_in;
  logic [PW-1:0]    neg_out;

  // The only negation hardware; its input is steered by state.
  always_comb begin
    neg_in = '0;
    case (state_q)
      S_NEGA:  neg_in = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      S_NEGB:  neg_in = {{WIDTH{b_q[WIDTH-1]}}, b_q};
      S_NEGP:  neg_in = acc_q;
      default: neg_in = '0;
    endcase
  end

  assign neg_out = ~neg_in + PW'(1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    nf_d    = nf_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = is_signed;
          nf_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_d = S_NEGA;
        end
      end
      S_NEGA: begin
        mag_a_d = (sgn_q & a_q[WIDTH-1]) ? neg_out[WIDTH-1:0] : a_q;
        state_d = S_NEGB;
      end
      S_NEGB: begin
        mag_b_d = (sgn_q & b_q[WIDTH-1]) ? neg_out[WIDTH-1:0] : b_q;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_MUL;
      end
      S_MUL: begin
        if (mag_b_q[0])
          acc_d = acc_q + (PW'(mag_a_q) << cnt_q);
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1))
          state_d = S_NEGP;
      end
      S_NEGP: begin
        prod_d  = nf_q ? neg_out : acc_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      nf_q    <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      nf_q    <= nf_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule
